// File: rtl/tape_pkg.sv
// Shared types and constants for the tape fastloader: trap profiles,
// loader state encoding, patch opcodes and RAM base addresses.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tape_state_e;

  typedef struct packed {
    logic        enable;
    logic [15:0] trap_start;
    logic [15:0] trap_end;
    logic [15:0] ret_addr;
  } trap_profile_t;

  localparam trap_profile_t PROFILE_ZX80 = '{1'b1, 16'h0207, 16'h024D, 16'h0203};
  localparam trap_profile_t PROFILE_ZX81 = '{1'b1, 16'h0347, 16'h03C3, 16'h0207};
  localparam trap_profile_t PROFILE_OFF  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
  localparam trap_profile_t PROFILES [0:1] = '{PROFILE_ZX80, PROFILE_ZX81};

  // Patch routine: XOR A ; NOP/SCF ; JR NC,-3 ; JP ret
  localparam logic [7:0] PATCH_XOR_A  = 8'hAF;
  localparam logic [7:0] PATCH_NOP    = 8'h00;
  localparam logic [7:0] PATCH_SCF    = 8'h37;
  localparam logic [7:0] PATCH_JR_NC  = 8'h30;
  localparam logic [7:0] PATCH_JR_OFS = 8'hFD;
  localparam logic [7:0] PATCH_JP     = 8'hC3;
  localparam logic [7:0] PATCH_FILL   = 8'hFF;

  localparam logic [15:0] BASE_O = 16'h4000;
  localparam logic [15:0] BASE_P = 16'h4009;

  // Map a profile selector to its table entry; unknown selectors are disabled.
  function automatic trap_profile_t get_profile(input logic [7:0] sel);
    trap_profile_t p;
    case (sel)
      8'd0:    p = PROFILES[0];
      8'd1:    p = PROFILES[1];
      default: p = PROFILE_OFF;
    endcase
    return p;
  endfunction

  // Byte the CPU sees at a given offset from the trap start.
  function automatic logic [7:0] patch_byte(input trap_profile_t prof,
                                            input logic [15:0] offset,
                                            input logic done);
    logic [7:0] b;
    case (offset)
      16'd0:   b = PATCH_XOR_A;
      16'd1:   b = done ? PATCH_SCF : PATCH_NOP;
      16'd2:   b = PATCH_JR_NC;
      16'd3:   b = PATCH_JR_OFS;
      16'd4:   b = PATCH_JP;
      16'd5:   b = prof.ret_addr[7:0];
      16'd6:   b = prof.ret_addr[15:8];
      default: b = PATCH_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tape_buffer.sv
// Tape image buffer: single-clock dual-port RAM, download write port and
// registered read port. Contents survive reset.
module tape_buffer #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk_sys,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem_r [0:(1<<DEPTH_LOG2)-1];

  // Write downloaded bytes and register the read data every cycle.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/tape_fastloader.sv
// ZX80/ZX81 tape fastloader: buffers a downloaded .o/.p image, traps the ROM
// loader on an M1 fetch, streams the image into main RAM and patches the ROM
// so the loader returns. Optional macro TAPE_CHECKSUM_EN enables the running
// checksum of streamed bytes; without it checksum reads 00h.
module tape_fastloader
  import tape_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14,
  parameter int NPROF      = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce_cpu_p,
  input  logic [$clog2(NPROF)-1:0] profile_sel,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic                     ioctl_sel,
  input  logic                     ioctl_fmt,
  input  logic [DEPTH_LOG2-1:0]    ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [15:0]              cpu_addr,
  input  logic                     nM1,
  output logic                     patch_sel,
  output logic [7:0]               patch_data,
  output logic                     ram_we,
  output logic [15:0]              ram_addr,
  output logic [7:0]               ram_data,
  output logic                     tape_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_abort,
  output logic [7:0]               checksum
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};

  logic                dl_r, nm1_r, fmt_r, tape_ready_r;
  logic                dl_rise_s, dl_fall_s, buf_we_s, m1_edge_s, outside_s;
  logic [DEPTH_LOG2:0] cnt_r, size_r, index_r, wr_idx_r;
  logic                rd_pend_r;
  logic [7:0]          rd_data_s;
  logic [15:0]         base_s;
  trap_profile_t       prof_s;
  tape_state_e         state_r, state_next_s;
  logic                enter_s, abort_s, issue_s, we_set_s, last_s;
  logic                ram_we_r, load_done_r, load_abort_r, patch_sel_r, load_busy_r;
  logic [15:0]         ram_addr_r;
  logic [7:0]          ram_data_r, patch_data_r;

  assign dl_rise_s = ioctl_download & ~dl_r & ioctl_sel;
  assign dl_fall_s = ~ioctl_download & dl_r & ioctl_sel;
  assign buf_we_s  = ioctl_download & ioctl_sel & ioctl_wr;
  assign m1_edge_s = nm1_r & ~nM1;
  assign prof_s    = get_profile(8'(profile_sel));
  assign outside_s = (cpu_addr < prof_s.trap_start) || (cpu_addr >= prof_s.trap_end);
  assign base_s    = fmt_r ? BASE_O : BASE_P;

  tape_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) u_buffer (
    .clk_sys (clk_sys),
    .wr_en   (buf_we_s),
    .wr_addr (ioctl_addr),
    .wr_data (ioctl_dout),
    .rd_addr (index_r[DEPTH_LOG2-1:0]),
    .rd_data (rd_data_s)
  );

  // Edge-detect history for the download window and the M1 strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_r  <= 1'b0;
      nm1_r <= 1'b1;
    end else begin
      dl_r  <= ioctl_download;
      nm1_r <= nM1;
    end
  end

  // Count downloaded bytes (saturating) and latch size/format when the window closes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_r        <= CNT_ZERO;
      size_r       <= CNT_ZERO;
      fmt_r        <= 1'b0;
      tape_ready_r <= 1'b0;
    end else begin
      if (dl_rise_s) begin
        cnt_r <= buf_we_s ? CNT_ONE : CNT_ZERO;
      end else if (buf_we_s && (cnt_r != CNT_CAP)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (dl_fall_s) begin
        size_r       <= cnt_r;
        fmt_r        <= ioctl_fmt;
        tape_ready_r <= (cnt_r != CNT_ZERO);
      end
    end
  end

  // Next-state logic: trap entry, byte issue, completion, exit and abort.
  always_comb begin
    state_next_s = state_r;
    enter_s      = 1'b0;
    abort_s      = 1'b0;
    issue_s      = 1'b0;
    we_set_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m1_edge_s && (cpu_addr == prof_s.trap_start) && tape_ready_r && prof_s.enable) begin
          state_next_s = ST_STREAM;
          enter_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (dl_rise_s) begin
          state_next_s = ST_IDLE;
          abort_s      = 1'b1;
        end else if (m1_edge_s && outside_s) begin
          state_next_s = ST_IDLE;
        end else begin
          issue_s  = ce_cpu_p && (index_r < size_r);
          we_set_s = rd_pend_r;
          if (rd_pend_r && (wr_idx_r == (size_r - CNT_ONE))) begin
            last_s       = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_STREAM;
          end
        end
      end
      ST_DONE: begin
        if (m1_edge_s && outside_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, streaming pipeline and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      index_r      <= CNT_ZERO;
      wr_idx_r     <= CNT_ZERO;
      rd_pend_r    <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= 16'h0000;
      ram_data_r   <= 8'h00;
      load_done_r  <= 1'b0;
      load_abort_r <= 1'b0;
      patch_sel_r  <= 1'b0;
      patch_data_r <= PATCH_FILL;
      load_busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (enter_s) begin
        index_r <= CNT_ZERO;
      end else if (issue_s) begin
        index_r <= index_r + CNT_ONE;
      end
      rd_pend_r <= issue_s;
      if (issue_s) begin
        wr_idx_r <= index_r;
      end
      ram_we_r <= we_set_s;
      if (we_set_s) begin
        ram_data_r <= rd_data_s;
        ram_addr_r <= base_s + 16'(wr_idx_r);
      end
      load_done_r  <= last_s;
      load_abort_r <= abort_s;
      patch_sel_r  <= (state_next_s != ST_IDLE);
      load_busy_r  <= (state_next_s != ST_IDLE);
      patch_data_r <= (state_next_s == ST_IDLE) ? PATCH_FILL :
                      patch_byte(prof_s, cpu_addr - prof_s.trap_start, state_next_s == ST_DONE);
    end
  end

`ifdef TAPE_CHECKSUM_EN
  logic [7:0] checksum_r;

  // Running modulo-256 sum of bytes written to RAM during a load.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum_r <= 8'h00;
    end else if (enter_s) begin
      checksum_r <= 8'h00;
    end else if (we_set_s) begin
      checksum_r <= checksum_r + rd_data_s;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 8'h00;
`endif

  assign patch_sel  = patch_sel_r;
  assign patch_data = patch_data_r;
  assign ram_we     = ram_we_r;
  assign ram_addr   = ram_addr_r;
  assign ram_data   = ram_data_r;
  assign tape_ready = tape_ready_r;
  assign load_busy  = load_busy_r;
  assign load_done  = load_done_r;
  assign load_abort = load_abort_r;

endmodule
